// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter: 8 requesters share one port. Emits a registered one-hot
// grant plus its encoded index. Grants hold until the owner drops its request,
// en drops, or the MAX_HOLD limit expires.
module rr_arbiter_8to3 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    // MAX_HOLD of 0 disables the limit, so the wrapped compare value is never used then
    localparam logic          HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_q, hold_d;

    logic          pick_found_c;
    logic [IW-1:0] pick_idx_c;
    logic          owner_req_c;
    logic          hold_hit_c;

    // First requester at or after the rotating pointer, wrapping modulo 8
    always_comb begin : pick
        logic [IW-1:0] cand;
        cand         = '0;
        pick_found_c = 1'b0;
        pick_idx_c   = ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_q + IW'(i);
            if (!pick_found_c && req[cand]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = cand;
            end
        end
    end

    assign owner_req_c = req[gnt_idx_q];
    assign hold_hit_c  = HOLD_EN && (hold_q == HOLD_LAST);

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (en && pick_found_c) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << pick_idx_c;
                    gnt_idx_d   = pick_idx_c;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                end
            end
            GRANT: begin
                if (!en || !owner_req_c || hold_hit_c) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + IW'(1);
                    // Only the hold limit can be the cause when en and req are both still high
                    timeout_d   = en && owner_req_c;
                end else begin
                    hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
